// File: rtl/mario_pkg.sv
// Shared types and key codes for the player motion controller.
package mario_pkg;

  typedef enum logic [1:0] {
    ST_FALL    = 2'd0,
    ST_GROUND  = 2'd1,
    ST_RISE    = 2'd2,
    ST_RESPAWN = 2'd3
  } motion_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

endpackage

// File: rtl/mario_motion_ctrl_jump_profile.sv
// Decaying upward-speed generator: loads JUMP_V0, drops 1 px/frame every DECAY_PERIOD ticks.
module jump_profile #(
  parameter int JUMP_V0      = 9,
  parameter int DECAY_PERIOD = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       clear,
  input  logic       tick,
  output logic [5:0] up_speed,
  output logic       done
);

  localparam int DCW = $clog2(DECAY_PERIOD + 1);

  logic [DCW-1:0] dcnt_q;
  logic           wrap;

  assign wrap = (dcnt_q == DCW'(DECAY_PERIOD - 1));
  // done looks ahead: the next tick would decrement the speed to zero
  assign done = wrap && (up_speed <= 6'd1);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      up_speed <= '0;
      dcnt_q   <= '0;
    end else if (clear) begin
      up_speed <= '0;
      dcnt_q   <= '0;
    end else if (load) begin
      up_speed <= 6'(JUMP_V0);
      dcnt_q   <= '0;
    end else if (tick) begin
      if (wrap) begin
        dcnt_q <= '0;
        if (up_speed != 6'd0) up_speed <= up_speed - 6'd1;
      end else begin
        dcnt_q <= dcnt_q + DCW'(1);
      end
    end
  end

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame player motion sequencer: keycode + collision flags -> registered velocity commands.
//  state   | meaning
//  FALL    | airborne, falling at TERMINAL
//  GROUND  | standing on floor, may walk or jump
//  RISE    | jumping, upward speed decays over time
//  RESPAWN | out of bounds, frozen until position reload settles
module mario_motion_ctrl
  import mario_pkg::*;
#(
  parameter int WALK_SPEED     = 2,
  parameter int TERMINAL       = 3,
  parameter int JUMP_V0        = 9,
  parameter int DECAY_PERIOD   = 6,
  parameter int Y_LIMIT        = 480,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       on_ground,
  input  logic       head_hit,
  input  logic       wall_left,
  input  logic       wall_right,
  input  logic [9:0] pos_y,
  output logic [5:0] vel_right,
  output logic [5:0] vel_left,
  output logic [5:0] vel_up,
  output logic [5:0] vel_down,
  output logic [1:0] state,
  output logic       respawn
);

  localparam int RCW = $clog2(RESPAWN_FRAMES + 1);

  motion_state_t  st_q, st_d;
  logic [RCW-1:0] rcnt_q;
  logic           jump_armed;
  logic           jp_load, jp_clear, jp_tick, jp_done;
  logic           oob;

  assign state = st_q;
  assign oob   = (st_q != ST_RESPAWN) && (pos_y > 10'(Y_LIMIT));

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_RESPAWN: if (rcnt_q == '0) st_d = ST_FALL;
      ST_FALL:    if (on_ground) st_d = ST_GROUND;
      ST_GROUND: begin
        if (!on_ground) st_d = ST_FALL;
        else if (keycode == KEY_JUMP && jump_armed && !head_hit) st_d = ST_RISE;
      end
      ST_RISE:    if (head_hit || jp_done) st_d = ST_FALL;
      default:    st_d = ST_FALL;
    endcase
    if (oob) st_d = ST_RESPAWN;
  end

  // up_speed is held at zero whenever we are not rising, so it drives vel_up directly
  assign jp_load  = (st_q != ST_RISE) && (st_d == ST_RISE);
  assign jp_tick  = (st_q == ST_RISE) && (st_d == ST_RISE);
  assign jp_clear = (st_d != ST_RISE);

  jump_profile #(
    .JUMP_V0      (JUMP_V0),
    .DECAY_PERIOD (DECAY_PERIOD)
  ) u_jump_profile (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .load      (jp_load),
    .clear     (jp_clear),
    .tick      (jp_tick),
    .up_speed  (vel_up),
    .done      (jp_done)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      st_q       <= ST_FALL;
      rcnt_q     <= '0;
      jump_armed <= 1'b1;
      respawn    <= 1'b0;
      vel_down   <= '0;
      vel_left   <= '0;
      vel_right  <= '0;
    end else begin
      st_q    <= st_d;
      respawn <= oob;

      if (oob)
        rcnt_q <= RCW'(RESPAWN_FRAMES - 1);
      else if (st_q == ST_RESPAWN && rcnt_q != '0)
        rcnt_q <= rcnt_q - RCW'(1);

      if (keycode != KEY_JUMP) jump_armed <= 1'b1;
      else if (jp_load)        jump_armed <= 1'b0;

      vel_down  <= (st_d == ST_FALL) ? 6'(TERMINAL) : 6'd0;
      vel_left  <= (st_d != ST_RESPAWN && keycode == KEY_LEFT && !wall_left)
                   ? 6'(WALK_SPEED) : 6'd0;
      vel_right <= (st_d != ST_RESPAWN && keycode == KEY_RIGHT && !wall_right)
                   ? 6'(WALK_SPEED) : 6'd0;
    end
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed scoreboard bench for mario_motion_ctrl.
module tb_mario_motion_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       on_ground, head_hit, wall_left, wall_right;
  logic [9:0] pos_y;
  logic [5:0] vel_right, vel_left, vel_up, vel_down;
  logic [1:0] state;
  logic       respawn;

  localparam logic [1:0] S_FALL = 2'd0, S_GND = 2'd1, S_RISE = 2'd2, S_RSP = 2'd3;

  typedef struct {
    string       tag;
    logic [26:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  checks   = 0;
  int  failures = 0;

  mario_motion_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .on_ground  (on_ground),
    .head_hit   (head_hit),
    .wall_left  (wall_left),
    .wall_right (wall_right),
    .pos_y      (pos_y),
    .vel_right  (vel_right),
    .vel_left   (vel_left),
    .vel_up     (vel_up),
    .vel_down   (vel_down),
    .state      (state),
    .respawn    (respawn)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [26:0] ev(logic [1:0] st, logic rs, int up, int dn, int l, int r);
    return {st, rs, 6'(up), 6'(dn), 6'(l), 6'(r)};
  endfunction

  function automatic logic [26:0] obs();
    return {state, respawn, vel_up, vel_down, vel_left, vel_right};
  endfunction

  task automatic drive(input logic [7:0] kc, input logic og, input logic hh,
                       input logic wl, input logic wr, input int py);
    keycode    = kc;
    on_ground  = og;
    head_hit   = hh;
    wall_left  = wl;
    wall_right = wr;
    pos_y      = 10'(py);
  endtask

  task automatic step(input string tag, input logic [26:0] exp);
    sb_t it;
    sbq.push_back('{tag, exp});
    @(posedge frame_clk);
    #1;
    it = sbq.pop_front();
    checks++;
    assert (obs() === it.exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", it.tag, obs(), it.exp);
    end
  endtask

  task automatic check_now(input string tag, input logic [26:0] exp);
    checks++;
    assert (obs() === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs(), exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    repeat (2) @(posedge frame_clk);
    #1;
    check_now("reset", ev(S_FALL, 0, 0, 0, 0, 0));
    @(negedge frame_clk);
    Reset = 1'b0;

    // landing
    step("fall_e1", ev(S_FALL, 0, 0, 3, 0, 0));
    step("fall_e2", ev(S_FALL, 0, 0, 3, 0, 0));
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("land_e3", ev(S_GND, 0, 0, 0, 0, 0));
    drive(8'h1A, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    step("jump_no_floor", ev(S_FALL, 0, 0, 3, 0, 0));
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("reland", ev(S_GND, 0, 0, 0, 0, 0));

    // full jump profile, key held 60 frames
    drive(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    for (int i = 0; i < 54; i++)
      step($sformatf("rise%0d", i), ev(S_RISE, 0, 9 - i / 6, 0, 0, 0));
    step("rise_end_fall", ev(S_FALL, 0, 0, 3, 0, 0));
    for (int i = 55; i < 60; i++)
      step($sformatf("held_no_rejump%0d", i), ev(S_GND, 0, 0, 0, 0, 0));
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("release", ev(S_GND, 0, 0, 0, 0, 0));

    // second jump, then head hit at vel_up=7
    drive(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    for (int i = 0; i <= 12; i++)
      step($sformatf("jump2_%0d", i), ev(S_RISE, 0, 9 - i / 6, 0, 0, 0));
    drive(8'h1A, 1'b1, 1'b1, 1'b0, 1'b0, 100);
    step("head_hit", ev(S_FALL, 0, 0, 3, 0, 0));
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("land_after_hit", ev(S_GND, 0, 0, 0, 0, 0));

    // horizontal with walls
    drive(8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("left_free", ev(S_GND, 0, 0, 0, 2, 0));
    drive(8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 100);
    step("left_wall", ev(S_GND, 0, 0, 0, 0, 0));
    drive(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 100);
    step("right_free", ev(S_GND, 0, 0, 0, 0, 2));
    drive(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 100);
    step("right_wall", ev(S_GND, 0, 0, 0, 0, 0));

    // out-of-bounds from FALL, limit itself is in bounds
    drive(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    step("walk_off", ev(S_FALL, 0, 0, 3, 0, 2));
    drive(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 480);
    step("y_at_limit", ev(S_FALL, 0, 0, 3, 0, 2));
    drive(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 481);
    step("oob_enter", ev(S_RSP, 1, 0, 0, 0, 0));
    for (int i = 1; i < 30; i++) begin
      if (i == 10) drive(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 100);
      step($sformatf("respawn%0d", i), ev(S_RSP, 0, 0, 0, 0, 0));
    end
    drive(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    step("respawn_exit", ev(S_FALL, 0, 0, 3, 0, 2));

    // out-of-bounds beats head_hit during RISE
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("land3", ev(S_GND, 0, 0, 0, 0, 0));
    drive(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("jump3", ev(S_RISE, 0, 9, 0, 0, 0));
    drive(8'h1A, 1'b1, 1'b1, 1'b0, 1'b0, 481);
    step("oob_over_hit", ev(S_RSP, 1, 0, 0, 0, 0));
    drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    for (int i = 1; i < 30; i++)
      step($sformatf("respawn_b%0d", i), ev(S_RSP, 0, 0, 0, 0, 0));
    step("respawn_b_exit", ev(S_FALL, 0, 0, 3, 0, 0));

    // reset mid-jump while the jump key stays held
    step("land4", ev(S_GND, 0, 0, 0, 0, 0));
    drive(8'h1A, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    step("jump4_0", ev(S_RISE, 0, 9, 0, 0, 0));
    for (int i = 1; i < 8; i++)
      step($sformatf("jump4_%0d", i), ev(S_RISE, 0, 9 - i / 6, 0, 0, 0));
    Reset = 1'b1;
    #2;
    check_now("async_reset", ev(S_FALL, 0, 0, 0, 0, 0));
    @(negedge frame_clk);
    Reset = 1'b0;
    step("post_reset_land", ev(S_GND, 0, 0, 0, 0, 0));
    step("post_reset_armed", ev(S_RISE, 0, 9, 0, 0, 0));
    step("post_reset_rise", ev(S_RISE, 0, 9, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mario_motion_ctrl.md
# mario_motion_ctrl

Per-frame motion sequencer for the player sprite. It turns the keyboard keycode and the collision flags from the collision unit into registered velocity commands (right/left/up/down magnitudes) for the position datapath. Internally it runs a grounded / rising / falling / respawn state machine with a decaying jump profile and an out-of-bounds respawn request. It sits between the USB keycode source and the position/collision datapath, and updates once per frame.

## Interface
- WALK_SPEED, 2: horizontal speed in px/frame.
- TERMINAL, 3: fall speed in px/frame.
- JUMP_V0, 9: initial upward speed.
- DECAY_PERIOD, 6: frames per 1 px/frame decrement of upward speed.
- Y_LIMIT, 480: pos_y above this triggers respawn.
- RESPAWN_FRAMES, 30: frames spent frozen in RESPAWN.
- frame_clk  in  1  frame clock (vsync rate).
- Reset  in  1  reset Reset, asynchronous, active-high.
- keycode  in  8  current key: 04 left, 07 right, 1A jump.
- on_ground  in  1  collision: floor below (downFlag).
- head_hit  in  1  collision: ceiling above (upFlag).
- wall_left / wall_right  in  1 each  side collisions.
- pos_y  in  10  current sprite top Y.
- vel_right, vel_left, vel_up, vel_down  out  6 each  registered speed magnitudes.
- state  out  2  FALL=0, GROUND=1, RISE=2, RESPAWN=3.
- respawn  out  1  one-frame pulse requesting position reload.

## Operation
- Reset: state FALL, all vel_* = 0, respawn = 0, up_speed = 0, decay count = 0, respawn count = 0, jump_armed = 1.
- jump_armed: cleared on RISE entry, set on any frame with keycode != 1A. A jump requires key release between jumps.
- Priority per edge: out-of-bounds > head_hit > normal transitions.
- Any state except RESPAWN, with pos_y > Y_LIMIT: go to RESPAWN, respawn = 1 for that frame, all vel_* = 0, load count = RESPAWN_FRAMES-1. pos_y is ignored while in RESPAWN.
- RESPAWN: count down each frame; at 0 go to FALL.
- FALL: vel_down = TERMINAL, vel_up = 0. If on_ground: go to GROUND.
- GROUND: vel_down = 0. If !on_ground: go to FALL. Else if keycode==1A, jump_armed and !head_hit: go to RISE.
- RISE entry: up_speed = JUMP_V0, decay count = 0, vel_up = JUMP_V0, vel_down = 0.
- RISE: each edge, decay count++. When the count was DECAY_PERIOD-1, it wraps to 0 and up_speed decrements. If the decrement yields 0, go to FALL.
- head_hit in RISE: immediate FALL, up_speed = 0.
- Horizontal, in FALL/GROUND/RISE:
  - keycode 04 and !wall_left: vel_left = WALK_SPEED, else 0.
  - keycode 07 and !wall_right: vel_right = WALK_SPEED, else 0.
  - vel_left and vel_right are never both nonzero.
  - In RESPAWN both are 0.
- Widths: up_speed is 6-bit unsigned and never decremented below 0. The out-of-bounds compare is unsigned 10-bit.

## Timing
- All outputs are registered on posedge frame_clk and reflect the state entered on that edge (1-frame input-to-output latency).
- RISE profile with defaults: vel_up = 9 for the first 6 frames, then 8, …, 1. FALL is entered on the 54th edge after RISE entry.
- Simultaneous events:
  - pos_y over limit during RISE takes RESPAWN.
  - Jump key with !on_ground in GROUND takes FALL.
- Reset mid-jump returns to FALL asynchronously. No partial profile is retained.

## Structure
- Shared package mario_pkg holds the state enum and the key constants KEY_LEFT=8'h04, KEY_RIGHT=8'h07, KEY_JUMP=8'h1A.
- One sub-module, jump_profile, owns up_speed and the decay counter. Its interface: load, clear, tick in; up_speed, done out.

## Test plan
- Reset, then on_ground=1 at edge 3 -> vel_down=3 for edges 1-2, state=GROUND and vel_down=0 from edge 3.
- GROUND, keycode=1A held 60 frames -> vel_up 9×6, 8×6, …, 1×6, FALL at edge 54. No second jump until keycode≠1A for one frame.
- RISE at vel_up=7, head_hit=1 -> next edge state=FALL, vel_up=0, vel_down=3.
- GROUND, keycode=04 with wall_left=0 then 1 -> vel_left=2, then 0 on the following edge. vel_right stays 0 throughout.
- pos_y=481 while in FALL -> respawn=1 for one frame, all vel_*=0 for 30 frames, then FALL with vel_down=3.
- Reset asserted mid-RISE -> all outputs 0 immediately, state=FALL, jump_armed=1.
